sort_engine: RTL and testbench

Sequential bubble-sort engine for the lab 4/5 data path. It collects DEPTH unsigned words over a valid/ready input stream and sorts them in place. Sorting uses the external `comparator` instance: the engine drives the comparator's A/B inputs and consumes its `is_great` result. It then streams the sorted words out in ascending order over a valid/ready output with a last marker.

---
 rtl/sort_engine.sv | 143 ++++++++++++++
 tb/tb_sort_engine.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_engine.sv
// sort_engine: batch bubble sorter driving an external comparator.
// Loads DEPTH words, sorts them in place, then streams them out ascending.
module sort_engine #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] cmp_a,
    output logic [WIDTH-1:0] cmp_b,
    input  logic             cmp_is_great,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             busy
);

    localparam int IW = $clog2(DEPTH);
    localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);
    localparam logic [IW-1:0] PASS_END = IW'(DEPTH - 2);

    typedef enum logic [1:0] {
        LOAD,
        SORT,
        DRAIN
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [IW-1:0]    cnt_q;
    logic [IW-1:0]    pass_q;
    logic [IW-1:0]    j_q;
    logic [IW-1:0]    j_nxt;
    logic             j_end;
    logic [WIDTH-1:0] data_buf [DEPTH];

    assign j_nxt = j_q + IW'(1);
    assign j_end = (j_q == (PASS_END - pass_q));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and output decode from registered state only.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        busy      = 1'b0;
        cmp_a     = '0;
        cmp_b     = '0;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        unique case (state_q)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && cnt_q == LAST) begin
                    state_d = SORT;
                end
            end
            SORT: begin
                busy  = 1'b1;
                cmp_a = data_buf[j_q];
                cmp_b = data_buf[j_nxt];
                if (j_end && pass_q == PASS_END) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = data_buf[cnt_q];
                out_last  = (cnt_q == LAST);
                if (out_ready && cnt_q == LAST) begin
                    state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // Load/drain index and bubble-sort pass/position counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            pass_q <= '0;
            j_q    <= '0;
        end else begin
            unique case (state_q)
                LOAD: begin
                    if (in_valid) begin
                        cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + IW'(1);
                    end
                end
                SORT: begin
                    if (j_end) begin
                        j_q    <= '0;
                        pass_q <= (pass_q == PASS_END) ? '0 : pass_q + IW'(1);
                    end else begin
                        j_q <= j_nxt;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + IW'(1);
                    end
                end
                default: begin
                    cnt_q  <= '0;
                    pass_q <= '0;
                    j_q    <= '0;
                end
            endcase
        end
    end

    // Word storage: fill during load, swap strictly-greater pairs during sort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_buf[i] <= '0;
            end
        end else begin
            if (state_q == LOAD && in_valid) begin
                data_buf[cnt_q] <= in_data;
            end else if (state_q == SORT && cmp_is_great) begin
                data_buf[j_q]   <= data_buf[j_nxt];
                data_buf[j_nxt] <= data_buf[j_q];
            end
        end
    end

endmodule

// File: tb/tb_sort_engine.sv
// tb_sort_engine: directed bench for sort_engine with a batch-level model.
// The model checks every cycle; literal expectations pin sorted results.
module tb_sort_engine;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic [7:0] cmp_a;
    logic [7:0] cmp_b;
    logic       cmp_is_great;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_last;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int rdy_mode = 0;
    int rdy_ph = 0;

    sort_engine #(.WIDTH(8), .DEPTH(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .cmp_a(cmp_a),
        .cmp_b(cmp_b),
        .cmp_is_great(cmp_is_great),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_last(out_last),
        .busy(busy)
    );

    assign cmp_is_great = cmp_a > cmp_b;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk1(string nm, logic act, logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk8(string nm, logic [7:0] act, logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h want %02h", nm, act, exp);
        end
    endtask

    task automatic chk32(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // Batch model: phase 0 collecting, 1 sorting (fixed 6 cycles), 2 draining.
    int         phase = 0;
    int         sort_left = 0;
    int         last_acc = 0;
    int         last_lat = -1;
    bit         prev_ov = 1'b0;
    logic [7:0] ld[$];
    logic [7:0] exp_q[$];
    logic [7:0] got[$];
    logic [7:0] tr_a[$];
    logic [7:0] tr_b[$];
    int         first_acc[$];

    function automatic void make_exp();
        logic [7:0] a[4];
        logic [7:0] t;
        for (int i = 0; i < 4; i++) a[i] = ld[i];
        for (int i = 0; i < 4; i++) begin
            for (int k = i + 1; k < 4; k++) begin
                if (a[k] < a[i]) begin
                    t = a[i];
                    a[i] = a[k];
                    a[k] = t;
                end
            end
        end
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(a[i]);
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            phase = 0;
            ld.delete();
            exp_q.delete();
            prev_ov = 1'b0;
            chk1("rst in_ready", in_ready, 1'b1);
            chk1("rst out_valid", out_valid, 1'b0);
            chk1("rst busy", busy, 1'b0);
            chk1("rst out_last", out_last, 1'b0);
            chk8("rst out_data", out_data, 8'h00);
            chk8("rst cmp_a", cmp_a, 8'h00);
            chk8("rst cmp_b", cmp_b, 8'h00);
        end else begin
            chk1("in_ready", in_ready, phase == 0);
            chk1("busy", busy, phase != 0);
            chk1("out_valid", out_valid, phase == 2);
            if (phase == 2) begin
                chk8("out_data", out_data, exp_q[0]);
                chk1("out_last", out_last, exp_q.size() == 1);
            end else begin
                chk8("idle out_data", out_data, 8'h00);
                chk1("idle out_last", out_last, 1'b0);
            end
            if (phase == 1) begin
                tr_a.push_back(cmp_a);
                tr_b.push_back(cmp_b);
            end else begin
                chk8("idle cmp_a", cmp_a, 8'h00);
                chk8("idle cmp_b", cmp_b, 8'h00);
            end
            if (out_valid && !prev_ov) last_lat = cyc - last_acc;
            prev_ov = out_valid;
            case (phase)
                0: if (in_valid) begin
                    if (ld.size() == 0) first_acc.push_back(cyc + 1);
                    ld.push_back(in_data);
                    if (ld.size() == 4) begin
                        make_exp();
                        ld.delete();
                        phase = 1;
                        sort_left = 6;
                        last_acc = cyc + 1;
                    end
                end
                1: begin
                    sort_left--;
                    if (sort_left == 0) phase = 2;
                end
                2: if (out_ready) begin
                    got.push_back(out_data);
                    void'(exp_q.pop_front());
                    if (exp_q.size() == 0) phase = 0;
                end
                default: phase = 0;
            endcase
        end
    end

    // Consumer: always ready, or the 1,0,0,1 backpressure pattern.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            rdy_ph++;
            out_ready = (rdy_mode == 0) || (rdy_ph % 4 == 0) || (rdy_ph % 4 == 3);
        end
    end

    task automatic push(logic [7:0] w);
        int k = 0;
        in_valid = 1'b1;
        while (!in_ready && k < 300) begin
            in_data = 8'($urandom);
            @(posedge clk);
            #1;
            k++;
        end
        if (!in_ready) chk1("push timeout", in_ready, 1'b1);
        in_data = w;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_out(int n, bit hold);
        int k = 0;
        while (got.size() < n && k < 300) begin
            if (hold) begin
                in_valid = 1'b1;
                in_data = 8'($urandom);
            end
            @(posedge clk);
            #1;
            k++;
        end
        in_valid = 1'b0;
        if (got.size() < n) chk32("drain timeout", got.size(), n);
    endtask

    task automatic expect4(string nm, int base, logic [7:0] a, logic [7:0] b,
                           logic [7:0] c, logic [7:0] d);
        logic [7:0] e[4];
        e[0] = a;
        e[1] = b;
        e[2] = c;
        e[3] = d;
        for (int i = 0; i < 4; i++) begin
            if (got.size() > base + i) chk8(nm, got[base + i], e[i]);
            else chk32({nm, " count"}, got.size(), base + 4);
        end
    endtask

    task automatic batch(logic [7:0] a, logic [7:0] b, logic [7:0] c, logic [7:0] d);
        got.delete();
        push(a);
        push(b);
        push(c);
        push(d);
        wait_out(4, 1'b1);
    endtask

    initial begin
        logic [7:0] ea[6];
        logic [7:0] eb[6];
        ea = '{8'h05, 8'hFF, 8'hFF, 8'h05, 8'h05, 8'h05};
        eb = '{8'hFF, 8'h05, 8'h00, 8'h05, 8'h00, 8'h00};

        repeat (2) @(posedge clk);
        #1;
        chk1("reset in_ready", in_ready, 1'b1);
        chk1("reset out_valid", out_valid, 1'b0);
        chk1("reset busy", busy, 1'b0);
        chk8("reset out_data", out_data, 8'h00);
        rst_n = 1'b1;

        batch(8'h30, 8'h10, 8'h40, 8'h20);
        expect4("basic", 0, 8'h10, 8'h20, 8'h30, 8'h40);
        chk32("basic latency", last_lat, 6);

        batch(8'h01, 8'h02, 8'h03, 8'h04);
        expect4("sorted", 0, 8'h01, 8'h02, 8'h03, 8'h04);
        chk32("sorted latency", last_lat, 6);

        batch(8'hFF, 8'h80, 8'h7F, 8'h00);
        expect4("reverse", 0, 8'h00, 8'h7F, 8'h80, 8'hFF);
        chk32("reverse latency", last_lat, 6);

        tr_a.delete();
        tr_b.delete();
        batch(8'h05, 8'hFF, 8'h05, 8'h00);
        expect4("dup", 0, 8'h00, 8'h05, 8'h05, 8'hFF);
        chk32("dup trace len", tr_a.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (tr_a.size() > i) begin
                chk8("dup trace a", tr_a[i], ea[i]);
                chk8("dup trace b", tr_b[i], eb[i]);
            end
        end

        rdy_mode = 1;
        batch(8'h33, 8'h11, 8'h44, 8'h22);
        expect4("backpressure", 0, 8'h11, 8'h22, 8'h33, 8'h44);
        rdy_mode = 0;
        idle(2);

        got.delete();
        push(8'hA0);
        push(8'hD0);
        push(8'hC0);
        push(8'hB0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk1("mid-sort busy", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("async rst in_ready", in_ready, 1'b1);
        chk1("async rst busy", busy, 1'b0);
        chk1("async rst out_valid", out_valid, 1'b0);
        chk8("async rst cmp_a", cmp_a, 8'h00);
        chk8("async rst cmp_b", cmp_b, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        batch(8'h09, 8'h08, 8'h07, 8'h06);
        expect4("after reset", 0, 8'h06, 8'h07, 8'h08, 8'h09);

        got.delete();
        first_acc.delete();
        push(8'h5A);
        idle(1);
        push(8'h3C);
        push(8'hA5);
        idle(1);
        push(8'h3C);
        push(8'h80);
        push(8'h01);
        push(8'hFE);
        push(8'h7F);
        push(8'h11);
        push(8'h99);
        push(8'h22);
        push(8'h88);
        wait_out(12, 1'b0);
        expect4("b2b gapped", 0, 8'h3C, 8'h3C, 8'h5A, 8'hA5);
        expect4("b2b second", 4, 8'h01, 8'h7F, 8'h80, 8'hFE);
        expect4("b2b third", 8, 8'h11, 8'h22, 8'h88, 8'h99);
        chk32("b2b batches", first_acc.size(), 3);
        if (first_acc.size() == 3) begin
            chk32("gapped period", first_acc[1] - first_acc[0], 16);
            chk32("min period", first_acc[2] - first_acc[1], 14);
        end

        idle(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
